// File: rtl/vending_credit_fsm.sv
// Vending machine credit FSM: coin accumulation, vend control, change return.
// Registered outputs; balance feeds the display stage in cents.
module vending_credit_fsm #(
  parameter int MAX_BALANCE = 250,
  parameter int PRICE_A     = 75,
  parameter int PRICE_B     = 100,
  parameter int PRICE_C     = 150,
  parameter int CHANGE_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_q,
  input  logic       coin_d,
  input  logic [1:0] sel,
  input  logic       buy,
  input  logic       refund,
  output logic [7:0] balance,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       coin_out,
  output logic       reject,
  output logic       busy
);

  localparam int CW = $clog2(CHANGE_GAP);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHANGE_GAP - 1);
  localparam logic [8:0] MAX9 = 9'(MAX_BALANCE);
  localparam logic [7:0] QTR = 8'd25;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0] bal_nx;
  logic [1:0] item_nx;
  logic vend_nx, cout_nx, rej_nx, busy_nx;

  logic q_h, d_h, buy_h, ref_h;
  logic ev_q, ev_d, ev_buy, ev_ref;
  logic coin_ev, can_buy;
  logic [7:0] price;
  logic [8:0] coin_val, sum;

  assign ev_q   = coin_q & ~q_h;
  assign ev_d   = coin_d & ~d_h;
  assign ev_buy = buy & ~buy_h;
  assign ev_ref = refund & ~ref_h;

  assign coin_ev  = ev_q | ev_d;
  assign coin_val = (ev_q ? 9'd25 : 9'd0)
                  + (ev_d ? 9'd100 : 9'd0);
  assign sum      = {1'b0, balance} + coin_val;

  always_comb begin
    price = 8'd0;
    unique case (sel)
      2'd0: price = 8'd0;
      2'd1: price = 8'(PRICE_A);
      2'd2: price = 8'(PRICE_B);
      2'd3: price = 8'(PRICE_C);
    endcase
  end

  assign can_buy = ev_buy
                 && (sel != 2'd0)
                 && (balance >= price);

  always_comb begin
    state_nx = state;
    bal_nx   = balance;
    cnt_nx   = cnt;
    vend_nx  = 1'b0;
    item_nx  = 2'd0;
    cout_nx  = 1'b0;
    rej_nx   = 1'b0;
    unique case (state)
      IDLE, CREDIT: begin
        if (state == CREDIT && ev_ref) begin
          state_nx = CHANGE;
          cnt_nx   = '0;
          rej_nx   = coin_ev;
        end else if (state == CREDIT && can_buy) begin
          state_nx = VEND;
          bal_nx   = balance - price;
          vend_nx  = 1'b1;
          item_nx  = sel;
          rej_nx   = coin_ev;
        end else if (coin_ev) begin
          if (sum <= MAX9) begin
            bal_nx   = sum[7:0];
            state_nx = CREDIT;
          end else begin
            rej_nx = 1'b1;
          end
        end
      end
      VEND: begin
        rej_nx   = coin_ev;
        cnt_nx   = '0;
        state_nx = (balance == 8'd0) ? IDLE : CHANGE;
      end
      CHANGE: begin
        rej_nx = coin_ev;
        // balance is kept a multiple of 25; the first arm only guards odd values
        if (balance < QTR) begin
          bal_nx   = 8'd0;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          cout_nx = 1'b1;
          bal_nx  = balance - QTR;
          cnt_nx  = '0;
          if (balance == QTR) state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == VEND) || (state_nx == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      balance   <= 8'd0;
      cnt       <= '0;
      vend      <= 1'b0;
      vend_item <= 2'd0;
      coin_out  <= 1'b0;
      reject    <= 1'b0;
      busy      <= 1'b0;
      q_h       <= 1'b1;
      d_h       <= 1'b1;
      buy_h     <= 1'b1;
      ref_h     <= 1'b1;
    end else begin
      state     <= state_nx;
      balance   <= bal_nx;
      cnt       <= cnt_nx;
      vend      <= vend_nx;
      vend_item <= item_nx;
      coin_out  <= cout_nx;
      reject    <= rej_nx;
      busy      <= busy_nx;
      q_h       <= coin_q;
      d_h       <= coin_d;
      buy_h     <= buy;
      ref_h     <= refund;
    end
  end

endmodule
